// File: rtl/ltc2308_responder.sv
// ltc2308_responder: behavioural LTC2308 ADC slave that answers a controller's CONVST/SPI frames
// Ports: clk, reset_n (async, active-low); adc_convst/adc_sck/adc_sdi from controller, adc_sdo back;
//        ch_data holds 8 x 12-bit samples; busy/conv_start/conv_ch report conversions;
//        cfg_valid/cfg_word/cfg_err report each complete config word received.
module ltc2308_responder #(
  parameter int TCONV_CYC = 64,
  parameter int CFG_BITS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  input  logic [95:0] ch_data,
  output logic        busy,
  output logic        conv_start,
  output logic [2:0]  conv_ch,
  output logic        cfg_valid,
  output logic [5:0]  cfg_word,
  output logic        cfg_err
);
  localparam int CW = $clog2(TCONV_CYC + 1);
  localparam logic [3:0] CB = 4'(CFG_BITS);
  localparam logic [3:0] CBL = 4'(CFG_BITS - 1);
  typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;
  state_t state, state_nx;
  logic [2:0] cv_s, sck_s;
  logic [1:0] sdi_s;
  logic [CW-1:0] cnt;
  logic [3:0] rcnt;
  logic [11:0] sr;
  logic [5:0] cs, nw;
  logic [2:0] pend;
  logic [6:0] base;
  logic cv_rise, sck_rise, sck_fall;
  always_comb begin
    cv_rise = cv_s[1] & ~cv_s[2];
    sck_rise = sck_s[1] & ~sck_s[2];
    sck_fall = ~sck_s[1] & sck_s[2];
    nw = {cs[4:0], sdi_s[1]};
    base = {1'b0, pend, 3'b0} + {2'b0, pend, 2'b0};
    busy = state == CONV;
    state_nx = cv_rise ? CONV :
               (state == CONV && cnt == '0) ? SHIFT :
               (state == SHIFT && sck_rise && rcnt == 4'd11) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv_s <= '0;
      sck_s <= '0;
      sdi_s <= '0;
      cnt <= '0;
      rcnt <= '0;
      sr <= '0;
      cs <= '0;
      pend <= '0;
      adc_sdo <= 1'b0;
      conv_start <= 1'b0;
      conv_ch <= '0;
      cfg_valid <= 1'b0;
      cfg_word <= 6'b100010;
      cfg_err <= 1'b0;
    end else begin
      cv_s <= {cv_s[1:0], adc_convst};
      sck_s <= {sck_s[1:0], adc_sck};
      sdi_s <= {sdi_s[0], adc_sdi};
      conv_start <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_err <= 1'b0;
      if (cv_rise) begin
        // restart from any state; a same-cycle SCK edge is dropped
        conv_start <= 1'b1;
        conv_ch <= pend;
        sr <= ch_data[base +: 12];
        cnt <= CW'(TCONV_CYC - 1);
        rcnt <= '0;
        cs <= '0;
        adc_sdo <= 1'b0;
      end else if (state == CONV) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) adc_sdo <= sr[11];
      end else if (state == SHIFT) begin
        // zeros shift in behind the result, so late falls drive 0
        if (sck_fall) begin
          adc_sdo <= sr[10];
          sr <= {sr[10:0], 1'b0};
        end
        if (sck_rise) begin
          rcnt <= rcnt + 4'd1;
          if (rcnt == 4'd11) adc_sdo <= 1'b0;
          if (rcnt < CB) cs <= nw;
          if (rcnt == CBL) begin
            cfg_word <= nw;
            cfg_valid <= 1'b1;
            cfg_err <= ~nw[5] | ~nw[1] | nw[0];
            pend <= {nw[3], nw[2], nw[4]};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder: directed scoreboard bench acting as the ADC controller
module tb_ltc2308_responder;
  localparam int TC = 64;
  logic clk = 0, reset_n = 0, adc_convst = 0, adc_sck = 0, adc_sdi = 0;
  logic adc_sdo, busy, conv_start, cfg_valid, cfg_err;
  logic [2:0] conv_ch;
  logic [5:0] cfg_word;
  logic [95:0] ch_data;
  logic [11:0] chd [8];
  logic [11:0] q [$];
  logic [2:0] pend_m = 0;
  logic [5:0] lw = 0;
  logic le = 0;
  int checks = 0, errors = 0, nv = 0, nerr = 0, en = 0;
  ltc2308_responder #(.TCONV_CYC(TC), .CFG_BITS(6)) dut (
    .clk(clk), .reset_n(reset_n), .adc_convst(adc_convst), .adc_sck(adc_sck),
    .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .ch_data(ch_data), .busy(busy),
    .conv_start(conv_start), .conv_ch(conv_ch), .cfg_valid(cfg_valid),
    .cfg_word(cfg_word), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = chd[i];
  always @(negedge clk) begin
    if (cfg_valid) begin
      nv++;
      lw = cfg_word;
      le = cfg_err;
    end
    if (cfg_err) nerr++;
  end
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", t, o, e);
    end
  endtask
  task automatic start_conv();
    int n;
    q.push_back(chd[pend_m]);
    adc_convst = 1;
    n = 0;
    while (!conv_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("conv_start_seen", {31'b0, conv_start}, 1);
    chk("conv_ch", {29'b0, conv_ch}, {29'b0, pend_m});
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", n, TC);
    adc_convst = 0;
  endtask
  task automatic shift(input int np, input logic [5:0] cfg, output logic [11:0] rd);
    rd = 0;
    for (int i = 0; i < np; i++) begin
      adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (5) @(negedge clk);
      if (i < 12) rd[11-i] = adc_sdo;
      adc_sck = 1;
      repeat (5) @(negedge clk);
      adc_sck = 0;
    end
    repeat (6) @(negedge clk);
  endtask
  task automatic finish(input logic [5:0] cfg, input int v0);
    logic [11:0] rd, e;
    logic er;
    shift(12, cfg, rd);
    e = q.pop_front();
    er = ~cfg[5] | ~cfg[1] | cfg[0];
    if (er) en++;
    chk("data", rd, e);
    chk("sdo_after", {31'b0, adc_sdo}, 0);
    chk("cfg_valid_cnt", nv - v0, 1);
    chk("cfg_word", lw, cfg);
    chk("cfg_err", {31'b0, le}, {31'b0, er});
    pend_m = {cfg[3], cfg[2], cfg[4]};
  endtask
  task automatic frame(input logic [5:0] cfg);
    int v0;
    v0 = nv;
    start_conv();
    finish(cfg, v0);
  endtask
  initial begin
    logic [11:0] rd, e;
    int v0;
    for (int i = 0; i < 8; i++) chd[i] = 12'(i * 12'h101);
    chd[0] = 12'hA5C;
    repeat (4) @(negedge clk);
    chk("rst_sdo", {31'b0, adc_sdo}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_conv_start", {31'b0, conv_start}, 0);
    chk("rst_cfg_valid", {31'b0, cfg_valid}, 0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 0);
    chk("rst_conv_ch", {29'b0, conv_ch}, 0);
    chk("rst_cfg_word", cfg_word, 6'b100010);
    reset_n = 1;
    repeat (3) @(negedge clk);
    frame(6'b110010);
    chd[0] = 12'h123;
    chd[1] = 12'hFED;
    frame(6'b000010);
    chd[0] = 12'h5A5;
    v0 = nv;
    start_conv();
    shift(3, 6'b101110, rd);
    e = q.pop_front();
    chk("abort_partial", rd[11:9], e[11:9]);
    chk("abort_no_valid", nv - v0, 0);
    start_conv();
    finish(6'b101110, v0);
    frame(6'b110110);
    v0 = nv;
    shift(8, 6'b111111, rd);
    chk("idle_sdo", rd, 0);
    chk("idle_no_valid", nv - v0, 0);
    start_conv();
    shift(5, 6'b110010, rd);
    e = q.pop_front();
    chk("rst_partial", rd[11:7], e[11:7]);
    reset_n = 0;
    #1;
    chk("midrst_sdo", {31'b0, adc_sdo}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_conv_ch", {29'b0, conv_ch}, 0);
    chk("midrst_cfg_word", cfg_word, 6'b100010);
    pend_m = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    v0 = nv;
    shift(12, 6'b110010, rd);
    chk("postrst_sdo", rd, 0);
    chk("postrst_no_valid", nv - v0, 0);
    frame(6'b100010);
    chk("cfg_err_pulses", nerr, en);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
